// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes and memory-port signals of the arbiter
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [1:0]  ls_size;
   logic        ls_sext;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic        mem_sext;
   logic [31:0] mem_wdata;
   logic        mem_wen;
   logic [31:0] mem_rdata;
   logic        busy;
   modport master (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_size, ls_sext, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_addr, mem_size, mem_sext, mem_wdata, mem_wen, busy
   );
   modport slave (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_size, ls_sext, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_addr, mem_size, mem_sext, mem_wdata, mem_wen, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between IF and LS with wait states and a starvation guard
module mem_port_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                CLK,
   input logic                RST,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d, starve_q, starve_d;
   logic        ls_q, ls_d, we_q, we_d, sext_q, sext_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
   logic        ls_win, if_win, acc, last;

   assign ls_win = bus.ls_req && !(starve_q == LIMIT && bus.if_req);
   assign if_win = bus.if_req && !ls_win;
   assign acc    = state_q == ACCESS;
   assign last   = acc && cnt_q == '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         ls_q       <= 1'b0;
         we_q       <= 1'b0;
         sext_q     <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         ls_q       <= ls_d;
         we_q       <= we_d;
         sext_q     <= sext_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      starve_d   = starve_q;
      ls_d       = ls_q;
      we_d       = we_q;
      sext_d     = sext_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;
      case (state_q)
         IDLE: begin
            if (ls_win || if_win) begin
               state_d = ACCESS;
               cnt_d   = WAIT_LD;
               ls_d    = ls_win;
               we_d    = ls_win && bus.ls_we;
               sext_d  = ls_win && bus.ls_sext;
               size_d  = ls_win ? bus.ls_size : 2'b10;
               addr_d  = ls_win ? bus.ls_addr : bus.if_addr;
               wdata_d = ls_win ? bus.ls_wdata : '0;
            end
            // in IDLE, if_req without an LS win always means an IF grant, so every other case clears
            starve_d = (ls_win && bus.if_req) ? (starve_q == LIMIT ? LIMIT : starve_q + 4'd1) : '0;
         end
         ACCESS: begin
            cnt_d = cnt_q - 4'd1;
            if (last) begin
               state_d = RESP;
               if (ls_q) ls_rdata_d = we_q ? '0 : bus.mem_rdata;
               else if_rdata_d = bus.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.if_gnt    = state_q == IDLE && if_win && !RST;
      bus.ls_gnt    = state_q == IDLE && ls_win && !RST;
      bus.if_rvalid = state_q == RESP && !ls_q;
      bus.ls_rvalid = state_q == RESP && ls_q;
      bus.if_rdata  = if_rdata_q;
      bus.ls_rdata  = ls_rdata_q;
      bus.busy      = state_q != IDLE;
      bus.mem_addr  = acc ? addr_q : '0;
      bus.mem_size  = acc ? size_q : '0;
      bus.mem_sext  = acc && sext_q;
      bus.mem_wdata = acc ? wdata_q : '0;
      bus.mem_wen   = !(last && we_q && !RST);
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random IF/LS traffic on two arbiter configurations against a transaction-level model
module tb_mem_port_arbiter;
   localparam int NCYC = 3000;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   bit init = 1'b1;
   bit done [2];

   typedef struct {
      logic        ls, we, sext;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
   } req_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic req_t mk(input logic ls, we, sext, input logic [1:0] size, input logic [31:0] addr, wdata);
      return '{ls, we, sext, size, addr, wdata};
   endfunction

   function automatic logic [31:0] iw(input int i);
      return i == 4 ? 32'hDEADBEEF : 32'(i) * 32'h9E3779B1;
   endfunction

   function automatic logic [31:0] ld(input logic [31:0] w, a, input logic [1:0] sz, input logic sx);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {a[1:0], 3'b000});
      h = 16'(w >> {a[1], 4'b0000});
      return sz == 2'b00 ? {{24{sx & b[7]}}, b} : sz == 2'b01 ? {{16{sx & h[15]}}, h} : w;
   endfunction

   function automatic logic [31:0] st(input logic [31:0] w, a, d, input logic [1:0] sz);
      logic [31:0] m, dd;
      m  = sz == 2'b00 ? 32'hFF << {a[1:0], 3'b000} : sz == 2'b01 ? 32'hFFFF << {a[1], 4'b0000} : '1;
      dd = sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
      return (w & ~m) | (dd & m);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int W = g ? 3 : 1;
      localparam int L = g ? 2 : 4;
      logic rst = 1'b1;
      logic [31:0] mem [64];
      mem_port_arbiter_if bus();
      mem_port_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(L)) dut (.CLK(clk), .RST(rst), .bus(bus));

      assign bus.mem_rdata = ld(mem[bus.mem_addr[7:2]], bus.mem_addr, bus.mem_size, bus.mem_sext);
      always @(negedge clk) begin
         if (init) for (int i = 0; i < 64; i++) mem[i] <= iw(i);
         else if (!bus.mem_wen) mem[bus.mem_addr[7:2]] <= st(mem[bus.mem_addr[7:2]], bus.mem_addr, bus.mem_wdata, bus.mem_size);
      end

      initial begin
         req_t ifr, lsr, t;
         req_t script [4];
         logic [31:0] ref_mem [64];
         logic [31:0] if_last, ls_last;
         int pos, starve, si, kept;
         bit ifp, lsp, ifs, egi, egl, acc, rv;
         for (int i = 0; i < 64; i++) ref_mem[i] = iw(i);
         script[0] = mk(1, 1, 0, 2'b00, 32'h21, 32'h123456A5);
         script[1] = mk(1, 0, 1, 2'b00, 32'h21, 32'h0);
         script[2] = mk(1, 1, 0, 2'b01, 32'h40, 32'hCAFE8001);
         script[3] = mk(1, 0, 0, 2'b01, 32'h40, 32'h0);
         t = mk(0, 0, 0, 2'b00, 0, 0);
         ifr = t;
         lsr = t;
         if_last = 0;
         ls_last = 0;
         pos = 0;
         starve = 0;
         si = 0;
         kept = -1;
         ifp = 0;
         lsp = 0;
         ifs = 0;
         for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (kept >= 0) begin
               chk("mem_kept", mem[kept], ref_mem[kept]);
               kept = -1;
            end
            if (!ifp && $urandom_range(0, 3) != 0) begin
               ifp = 1;
               ifr = mk(0, 0, 0, 2'b10, ifs ? $urandom : 32'h10, 0);
               ifs = 1;
            end
            if (!lsp && $urandom_range(0, 3) != 0) begin
               lsp = 1;
               lsr = si < 4 ? script[si] : mk(1, 1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom);
               si++;
            end
            rst = c < 3 || (pos == W && t.we && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
            bus.if_req   = ifp;
            bus.if_addr  = ifp ? ifr.addr : $urandom;
            bus.ls_req   = lsp;
            bus.ls_we    = lsp ? lsr.we : 1'($urandom);
            bus.ls_addr  = lsp ? lsr.addr : $urandom;
            bus.ls_size  = lsp ? lsr.size : 2'($urandom);
            bus.ls_sext  = lsp ? lsr.sext : 1'($urandom);
            bus.ls_wdata = lsp ? lsr.wdata : $urandom;
            @(negedge clk);
            if (rst) begin
               chk("mem_wen_rst", 32'(bus.mem_wen), 32'd1);
               if (pos == W && t.we) kept = int'(t.addr[7:2]);
               pos = 0;
               starve = 0;
               if_last = 0;
               ls_last = 0;
               continue;
            end
            egl = pos == 0 && lsp && !(starve == L && ifp);
            egi = pos == 0 && ifp && !egl;
            acc = pos >= 1 && pos <= W;
            rv  = pos == W + 1;
            if (rv) begin
               if (t.ls) ls_last = t.we ? 0 : ld(ref_mem[t.addr[7:2]], t.addr, t.size, t.sext);
               else if_last = ld(ref_mem[t.addr[7:2]], t.addr, t.size, t.sext);
            end
            chk("if_gnt", 32'(bus.if_gnt), 32'(egi));
            chk("ls_gnt", 32'(bus.ls_gnt), 32'(egl));
            chk("busy", 32'(bus.busy), 32'(pos != 0));
            chk("mem_addr", bus.mem_addr, acc ? t.addr : 0);
            chk("mem_size", 32'(bus.mem_size), acc ? 32'(t.size) : 0);
            chk("mem_sext", 32'(bus.mem_sext), 32'(acc && t.sext));
            if (!(acc && !t.ls)) chk("mem_wdata", bus.mem_wdata, acc ? t.wdata : 0);
            chk("mem_wen", 32'(bus.mem_wen), 32'(!(pos == W && t.we)));
            chk("if_rvalid", 32'(bus.if_rvalid), 32'(rv && !t.ls));
            chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(rv && t.ls));
            chk("if_rdata", bus.if_rdata, if_last);
            chk("ls_rdata", bus.ls_rdata, ls_last);
            if (pos == 0) begin
               starve = (egl && ifp) ? (starve == L ? L : starve + 1) : 0;
               if (egl || egi) begin
                  t = egl ? lsr : ifr;
                  pos = 1;
                  if (egl) lsp = 0;
                  else ifp = 0;
               end
            end else begin
               if (pos == W && t.we) ref_mem[t.addr[7:2]] = st(ref_mem[t.addr[7:2]], t.addr, t.wdata, t.size);
               pos = pos == W + 1 ? 0 : pos + 1;
            end
         end
         done[g] = 1'b1;
      end
   end

   initial begin
      @(negedge clk);
      #1 init = 1'b0;
      repeat (NCYC + 5) @(posedge clk);
      chk("done", 32'({done[1], done[0]}), 32'd3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Serialises accesses through a small FSM with a programmable wait-state count.
- Drives the memory's address, size, sign-extend, write data and active-low write enable (writes land on the negedge).
- Returns read data to the winning requester through a one-cycle valid pulse.
- LS has fixed priority, with a starvation guard so IF is eventually served.

Parameters:
WAIT_CYCLES, 1, cycles the memory port is driven per access (legal range 1..15)
STARVE_LIMIT, 4, consecutive LS grants allowed while if_req is pending before IF is forced to win (legal range 1..15)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous reset, active-high
if_req  in  1  IF access request; hold with if_addr until granted
if_addr  in  32  IF byte address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched word
ls_req  in  1  LS access request; hold with payload until granted
ls_we  in  1  1 = store, 0 = load
ls_addr  in  32  LS byte address
ls_size  in  2  00 byte, 01 half, 10/11 word
ls_sext  in  1  1 = sign-extend load
ls_wdata  in  32  store data
ls_gnt  out  1  LS request accepted this cycle
ls_rvalid  out  1  one-cycle completion pulse, for loads and stores
ls_rdata  out  32  load data; 0 on store completion
mem_addr  out  32  memory address
mem_size  out  2  memory size
mem_sext  out  1  memory sign-extend select
mem_wdata  out  32  memory write data
mem_wen  out  1  memory write enable, active-low
mem_rdata  in  32  memory read data (combinational)
busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ACCESS, RESP. Reset value: IDLE.
- Reset values: all outputs 0 except mem_wen = 1; wait counter = 0; starvation counter = 0; latched request registers = 0.
- IDLE, grants:
  - if_gnt and ls_gnt are combinational, asserted only in IDLE, never both in one cycle.
  - Winner is LS if ls_req=1, unless starve_cnt == STARVE_LIMIT and if_req=1; otherwise IF if if_req=1.
- IDLE, on a granted posedge:
  - Latch requester id, addr, size, sext, we, wdata.
  - For IF, latch size=10, sext=0, we=0.
  - Load wait counter with WAIT_CYCLES-1 and go to ACCESS.
- Starvation counter:
  - +1, saturating at STARVE_LIMIT, on each LS grant while if_req=1.
  - Cleared on an IF grant, or in any IDLE cycle with if_req=0.
- ACCESS:
  - mem_addr, mem_size, mem_sext and mem_wdata are driven from the latched registers.
  - Counter decrements each cycle.
  - mem_wen = 0 only in the final ACCESS cycle (counter == 0), only when latched we = 1, and only when RST = 0. This is gated combinationally so a reset can never produce a write.
  - On the final posedge: capture mem_rdata (or 0 for a store) into the response register and go to RESP.
- RESP:
  - Pulse if_rvalid or ls_rvalid (the latched winner) for exactly one cycle; rdata is held until the next response.
  - mem_* return to idle values (mem_wen = 1, others 0). Next state: IDLE.
- Latency: grant in cycle T, rvalid in cycle T + WAIT_CYCLES + 1. Minimum throughput: one access per WAIT_CYCLES + 2 cycles.
- Requests arriving while busy are ignored until IDLE; gnt stays 0 and the requester keeps req high.
- Simultaneous if_req and ls_req in IDLE: LS wins, subject to the starvation rule.
- Reset mid-operation: at the next posedge the FSM returns to IDLE and any pending rvalid is dropped. No partial write occurs.
- Addresses pass through unaltered; the memory performs its own alignment masking. The arbiter performs no misalignment check.

Test Plan:
- WAIT_CYCLES=1. IF request to 0x10 with mem word 0xDEADBEEF → if_gnt at T, mem_addr=0x10 at T+1, if_rvalid at T+2 with if_rdata=0xDEADBEEF.
- LS store of byte 0xA5 to 0x21 → mem_wen=0 for exactly one cycle with mem_size=00 and mem_wdata[7:0]=A5. A subsequent signed byte load from 0x21 returns ls_rdata=0xFFFFFFA5.
- if_req and ls_req both held continuously with STARVE_LIMIT=4 → grant order LS, LS, LS, LS, IF, LS, …; if_gnt never stays 0 across more than 5 arbitrations.
- WAIT_CYCLES=3. Halfword unsigned load of 0x8001 → mem_* stable for 3 cycles, ls_rvalid at T+4, ls_rdata=0x00008001.
- RST asserted during the final ACCESS cycle of a store → mem_wen stays 1, memory unchanged, busy=0 and no rvalid on the next cycle.
